// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot and binary grant outputs.
// Optional hold-time limit compiled in with `define RR_ARBITER_TIMEOUT_EN.
module rr_arbiter_8 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       tmo
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_arbiter_8: TIMEOUT must be within 2..255");
  end

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  state_e     state_q;
  logic [2:0] ptr_q;

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;
`endif

  // Rotating priority search: lowest offset from ptr_q wins, so scan offsets high to low.
  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      tmo       <= 1'b0;
      ptr_q     <= 3'd0;
`ifdef RR_ARBITER_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      tmo <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_found) begin
            gnt       <= 8'b1 << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            state_q   <= StGrant;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q     <= 8'd0;
`endif
          end
        end
        StGrant: begin
          if (!req[gnt_idx]) begin
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
            ptr_q     <= gnt_idx + 3'd1;
            state_q   <= StIdle;
          end
`ifdef RR_ARBITER_TIMEOUT_EN
          // Forced release: the owner drops to lowest priority like a normal release.
          else if (cnt_q == CntLast) begin
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
            ptr_q     <= gnt_idx + 3'd1;
            state_q   <= StIdle;
            tmo       <= 1'b1;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: vector table, directed corner sequences,
// and randomized requests checked against a behavioural round-robin model.
module tb_rr_arbiter_8;

  localparam int TMO = 4;
`ifdef RR_ARBITER_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       tmo;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arbiter_8 #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .tmo      (tmo)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the resource, how long they've held it, who is next in line.
  int         m_owner;
  int         m_ptr;
  int         m_hold;
  logic [2:0] m_idx;
  logic       m_tmo;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_idx   = 3'd0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (r[c]) begin
          m_owner = c;
          m_idx   = 3'(c);
          m_hold  = 1;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (TmoEn && m_hold >= TMO) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_tmo   = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  function automatic logic [7:0] model_gnt();
    if (m_owner < 0) return 8'h00;
    return 8'(1 << m_owner);
  endfunction

  task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic et);
    n_tests++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || tmo !== et) begin
      n_fail++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b tmo=%b, want gnt=%h idx=%0d valid=%b tmo=%b",
               name, gnt, gnt_idx, gnt_valid, tmo, eg, ei, ev, et);
    end
  endtask

  task automatic check_model(input string name);
    check(name, model_gnt(), m_idx, m_owner >= 0, m_tmo);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(req);
    #1;
  endtask

  task automatic do_reset();
    req = 8'h00;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Idle, single-owner hold/release, wraparound search from ptr=5, then ptr=1 -> index 3.
    vecs[0]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[6]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[7]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[8]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[11] = '{8'h00, 8'h00, 3'd4, 1'b0, 1'b0};
    vecs[12] = '{8'h09, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[13] = '{8'h08, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[15] = '{8'h00, 8'h00, 3'd3, 1'b0, 1'b0};

    rst = 1'b1;
    #2;
    check("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
    do_reset();
    check("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);

    for (int v = 0; v < 16; v++) begin
      req = vecs[v].req;
      step();
      check($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].idx, vecs[v].valid, vecs[v].tmo);
    end

    // All requesting: each owner drops for one edge, so grants rotate 0..7 then wrap to 0.
    do_reset();
    for (int g = 0; g < 9; g++) begin
      req = 8'hFF;
      step();
      check($sformatf("rot_grant%0d", g), 8'(1 << (g % 8)), 3'(g % 8), 1'b1, 1'b0);
      req = 8'hFF & ~8'(1 << (g % 8));
      step();
      check($sformatf("rot_release%0d", g), 8'h00, 3'(g % 8), 1'b0, 1'b0);
    end

    // Held request: forced release after TMO cycles when the limit is compiled in.
    do_reset();
    req = 8'h06;
    for (int k = 0; k < 6; k++) begin
      step();
      if (TmoEn && k == 4)
        check($sformatf("hold%0d", k), 8'h00, 3'd1, 1'b0, 1'b1);
      else if (TmoEn && k == 5)
        check($sformatf("hold%0d", k), 8'h04, 3'd2, 1'b1, 1'b0);
      else
        check($sformatf("hold%0d", k), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    req = 8'h00;
    step();
    check_model("hold_drop");

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 8'h10;
    step();
    check("pre_rst_grant", 8'h10, 3'd4, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_drop", 8'h00, 3'd0, 1'b0, 1'b0);
    model_reset();
    req = 8'h11;
    #2;
    rst = 1'b0;
    step();
    check("post_rst_grant", 8'h01, 3'd0, 1'b1, 1'b0);

    // Randomized traffic; owners usually keep requesting so long grants occur.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      if (m_owner >= 0 && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
      req = r;
      step();
      check_model($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter granting one of eight requesters access to a shared resource. The winner is presented both as a one-hot grant vector and as a 3-bit binary index, so it feeds the shared resource's select logic directly. The grant is held until the owner drops its request, or until an optional hold-time limit expires. The block sits between the eight client request lines and the resource's mux/select.

## Interface
- `TIMEOUT`, 16: maximum consecutive grant cycles when the timeout feature is compiled in. Legal range 2..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request lines; bit i is requester i. Level-sensitive.
- `gnt`  out  8  one-hot grant, registered; all zero when there is no grant.
- `gnt_idx`  out  3  binary index of the granted requester, registered; holds its last value while `gnt_valid`=0.
- `gnt_valid`  out  1  high while any grant is active; equals `|gnt`.
- `tmo`  out  1  one-cycle pulse marking a forced release.

## Operation
- Two-state FSM: IDLE and GRANT.
- Registers:
  - state
  - `gnt`, `gnt_idx`, `gnt_valid`, `tmo`
  - `ptr[2:0]`: highest-priority position
  - `cnt[7:0]`: grant-length counter
- Reset values: state=IDLE, `gnt`=8'h00, `gnt_idx`=3'd0, `gnt_valid`=0, `tmo`=0, `ptr`=3'd0, `cnt`=0.
- IDLE, `req`=0: remain in IDLE; outputs unchanged.
- IDLE, `req`≠0: the winner is the first set bit searching `ptr`, `ptr`+1, … `ptr`+7, mod 8. On the next edge:
  - `gnt` = one-hot(winner), `gnt_idx` = winner, `gnt_valid` = 1
  - `cnt` = 0, state = GRANT
- GRANT, `req[gnt_idx]`=1 (no timeout): hold `gnt`, `gnt_idx` and `gnt_valid`; `cnt` increments each edge, saturating at 255.
- GRANT, `req[gnt_idx]`=0 sampled at an edge: at that edge
  - `gnt` = 0, `gnt_valid` = 0
  - `ptr` = `gnt_idx`+1 (mod 8, so 7 wraps to 0)
  - state = IDLE
- Other requesters' lines have no effect while in GRANT. There is no preemption.
- Re-arbitration always passes through one IDLE cycle, so the minimum gap between grants is one cycle.
- `gnt` is never multi-hot. `gnt_idx` is never updated without a new grant.
- Asynchronous `rst` mid-grant: all outputs drop immediately to their reset values, with no wait for a clock edge. Arbitration restarts with `ptr`=0.

## Timing
- Request-to-grant latency: 1 edge from the edge at which `req` is first sampled nonzero in IDLE.
- Release latency: `gnt` falls on the same edge at which the owner's dropped request is sampled.
- Minimum grant length: 1 cycle (owner drops its request immediately).
- Back-to-back service:
  - grant cycles of requester A
  - 1 IDLE cycle
  - requester B granted on the following edge
- `tmo` is high for exactly one cycle: the cycle after a forced release.
- All outputs are registered. There are no combinational paths from `req` to any output.

## Configuration
- Macro: `RR_ARBITER_TIMEOUT_EN`.
- Defined:
  - In GRANT, when `cnt` = `TIMEOUT`-1 and `req[gnt_idx]` is still 1, the arbiter releases at that edge exactly as for a normal release (`gnt`=0, `ptr`=`gnt_idx`+1, IDLE) and sets `tmo`=1 for one cycle.
  - `gnt` is therefore high for at most `TIMEOUT` consecutive cycles.
  - A still-requesting former owner competes again at lowest priority.
  - If the owner drops its request on the same edge the timeout would fire, the release counts as normal and `tmo` stays 0.
- Undefined: there is no hold-time limit, `tmo` is tied to 0, and `cnt` may be omitted.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles -> `gnt`=8'h00, `gnt_idx`=0, `gnt_valid`=0, `tmo`=0 throughout.
- `req`=8'h01, held 3 cycles after grant, then 8'h00 -> `gnt`=8'h01 and `gnt_idx`=0 one edge after the request; grant held 3 cycles, released on the drop edge; `ptr`=1.
- `req`=8'hFF held constant, each owner dropping its bit 1 cycle after being granted and re-raising it next cycle -> grant order 0,1,2,…,7,0, each separated by one IDLE cycle; `ptr` wraps from 7 to 0.
- `ptr`=5 and `req`=8'h09 -> grant index 0 (search order 5,6,7,0), then `ptr`=1 after release. Next grant goes to index 3.
- `RR_ARBITER_TIMEOUT_EN` defined, `TIMEOUT`=4, `req`=8'h06 held -> `gnt`=8'h02 for exactly 4 cycles, `tmo` pulse, IDLE cycle, then `gnt`=8'h04. Without the macro, `gnt`=8'h02 holds indefinitely and `tmo` stays 0.
- `rst` asserted mid-cycle during `gnt`=8'h10 -> `gnt`=0 and `gnt_valid`=0 without waiting for a clock edge. After deassertion with `req`=8'h11, index 0 is granted (`ptr`=0).
